// File: rtl/rv32i_types.sv
// Shared types and constants for the line burst scheduler.
package rv32i_types;

  localparam int LBS_NBEAT    = 4;
  localparam int LBS_OFFSET_W = 5;
  localparam int LBS_CNT_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    RD_D,
    WB,
    RESP
  } lbs_state_t;

  // Which requester the RESP state answers; K_WB means a buffer drain with no response.
  typedef enum logic [1:0] {
    K_I,
    K_D,
    K_WB
  } lbs_kind_t;

endpackage

// File: rtl/lbs_wb_buffer.sv
// One-entry posted writeback buffer: line + address with valid, line-address match and beat read port.
module lbs_wb_buffer
  import rv32i_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [LINE_W-1:0]    line_i,
  input  logic [ADDR_W-1:0]    probe_addr_i,
  input  logic [LBS_CNT_W-1:0] beat_i,
  output logic                 vld_o,
  output logic                 match_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [LINE_W-1:0]    line_o,
  output logic [BURST_W-1:0]   beat_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LBS_OFFSET_W) - ADDR_W'(1));

  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      line_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      addr_q <= addr_i;
      line_q <= line_i;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end
  end

  // Offset bits are ignored: any address within the buffered line is a hit.
  assign match_o = vld_q && (((probe_addr_i ^ addr_q) & LINE_MASK) == '0);
  assign vld_o   = vld_q;
  assign addr_o  = addr_q;
  assign line_o  = line_q;
  assign beat_o  = line_q[beat_i*BURST_W +: BURST_W];

endmodule

// File: rtl/line_burst_scheduler.sv
// Arbitrates I fills, D fills and posted D writebacks onto a 4-beat burst port.
// Optional LBS_WB_FWD_EN: reads that hit the posted line are answered from the buffer.
module line_burst_scheduler
  import rv32i_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_read_i,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [LINE_W-1:0]  i_line_o,
  output logic               i_resp_o,
  input  logic               d_read_i,
  input  logic               d_write_i,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [LINE_W-1:0]  d_line_i,
  output logic [LINE_W-1:0]  d_line_o,
  output logic               d_resp_o,
  input  logic               resp_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic               stall_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LBS_OFFSET_W) - ADDR_W'(1));
  localparam logic [LBS_CNT_W-1:0] LAST_BEAT = LBS_CNT_W'(LBS_NBEAT - 1);

  lbs_state_t            state_q, state_d;
  lbs_kind_t             kind_q, kind_d;
  logic [LBS_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LINE_W-1:0]     line_q;

  logic                  buf_load, buf_clr, buf_vld, buf_hit;
  logic [ADDR_W-1:0]     buf_addr;
  logic [LINE_W-1:0]     buf_line;
  logic [BURST_W-1:0]    buf_beat;
  logic                  fwd, beat_take;

  lbs_wb_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .ADDR_W  (ADDR_W)
  ) u_wb_buffer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (buf_load),
    .clr_i        (buf_clr),
    .addr_i       (d_address),
    .line_i       (d_line_i),
    .probe_addr_i (d_read_i ? d_address : i_address),
    .beat_i       (cnt_q),
    .vld_o        (buf_vld),
    .match_o      (buf_hit),
    .addr_o       (buf_addr),
    .line_o       (buf_line),
    .beat_o       (buf_beat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kind_q  <= K_I;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    buf_load  = 1'b0;
    buf_clr   = 1'b0;
    fwd       = 1'b0;
    beat_take = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    i_resp_o  = 1'b0;
    d_resp_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // A second writeback behind a full buffer forces the drain before anything else.
        if (buf_vld && d_write_i) begin
          state_d = WB;
          kind_d  = K_WB;
          addr_d  = buf_addr & LINE_MASK;
        end else if (d_write_i) begin
          buf_load = 1'b1;
          kind_d   = K_D;
          state_d  = RESP;
        end else if (d_read_i || i_read_i) begin
          if (buf_hit) begin
`ifdef LBS_WB_FWD_EN
            fwd     = 1'b1;
            kind_d  = d_read_i ? K_D : K_I;
            state_d = RESP;
`else
            state_d = WB;
            kind_d  = K_WB;
            addr_d  = buf_addr & LINE_MASK;
`endif
          end else if (d_read_i) begin
            state_d = RD_D;
            kind_d  = K_D;
            addr_d  = d_address & LINE_MASK;
          end else begin
            state_d = RD_I;
            kind_d  = K_I;
            addr_d  = i_address & LINE_MASK;
          end
        end else if (buf_vld) begin
          state_d = WB;
          kind_d  = K_WB;
          addr_d  = buf_addr & LINE_MASK;
        end
      end
      RD_I, RD_D, WB: begin
        read_o  = (state_q != WB);
        write_o = (state_q == WB);
        if (resp_i) begin
          beat_take = 1'b1;
          cnt_d     = cnt_q + LBS_CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        i_resp_o = (kind_q == K_I);
        d_resp_o = (kind_q == K_D);
        buf_clr  = (kind_q == K_WB);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
    end else if (fwd) begin
      line_q <= buf_line;
    end else if (beat_take && read_o) begin
      line_q[cnt_q*BURST_W +: BURST_W] <= burst_i;
    end
  end

  assign i_line_o  = line_q;
  assign d_line_o  = line_q;
  assign address_o = (read_o || write_o) ? addr_q : '0;
  assign burst_o   = write_o ? buf_beat : '0;
  assign stall_o   = reset_n & ((i_read_i & ~i_resp_o) |
                                ((d_read_i | d_write_i) & ~d_resp_o));

endmodule
